// File: rtl/reg_sweeper.sv
// reg_sweeper: register-number sweep sequencer for the register-file test datapath.
// A go pulse presents START, then steps COUNT (or 2*COUNT) register numbers
// down, up, or out-and-back, stallable by hold, and parks in DONE until the next go.
module reg_sweeper #(
  parameter int unsigned REGW  = 5,
  parameter int unsigned START = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            go,
  input  logic [1:0]      mode,
  input  logic            hold,
  output logic [REGW-1:0] regnum,
  output logic            active,
  output logic            done
);

  // Wide enough to hold 2*COUNT, the last index of an out-and-back sweep.
  localparam int unsigned KW = $clog2(2 * COUNT + 1);

  localparam logic [KW-1:0]   KOne      = KW'(1);
  localparam logic [KW-1:0]   KCount    = KW'(COUNT);
  localparam logic [KW-1:0]   KLastLong = KW'(2 * COUNT);
  localparam logic [REGW-1:0] Base      = REGW'(START);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSweep,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [1:0]      mode_q, mode_d;
  logic [REGW-1:0] regnum_q, regnum_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic [KW-1:0]   last_k;

  // Register number shown at step k; offsets wrap modulo 2^REGW.
  function automatic logic [REGW-1:0] sweep_val(input logic [1:0] m, input logic [KW-1:0] k);
    logic [KW-1:0]   mag;
    logic [REGW-1:0] mag_r;
    logic            down;
    if (m[1] && (k > KCount)) begin
      mag = KLastLong - k;  // return leg walks back toward the base
    end else begin
      mag = k;
    end
    mag_r = REGW'(mag);
    down  = (m == 2'b00) || (m == 2'b11);
    return down ? (Base - mag_r) : (Base + mag_r);
  endfunction

  // Out-and-back modes run two legs.
  assign last_k = mode_q[1] ? KLastLong : KCount;

  // Next-state, step index and latched mode.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (!go) begin
          state_d = StSweep;
          mode_d  = mode;
          k_d     = KOne;
        end
      end
      StSweep: begin
        // go and mode are deliberately ignored here; a sweep always completes.
        if (!hold) begin
          if (k_q < last_k) begin
            k_d = k_q + KOne;
          end else begin
            state_d = StDone;
            k_d     = '0;
          end
        end
      end
      StDone: begin
        if (go) begin
          state_d = StStart;
        end
      end
      default: begin
        state_d = StIdle;
        k_d     = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they can be registered with it.
  always_comb begin
    regnum_d = '0;
    active_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      StIdle: begin
        regnum_d = '0;
      end
      StStart: begin
        regnum_d = Base;
        active_d = 1'b1;
      end
      StSweep: begin
        regnum_d = sweep_val(mode_d, k_d);
        active_d = 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        regnum_d = '0;
      end
    endcase
  end

  // State, step index, latched mode and registered outputs; reset is asynchronous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      mode_q   <= 2'b00;
      regnum_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mode_q   <= mode_d;
      regnum_q <= regnum_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign regnum = regnum_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_reg_sweeper.sv
// Directed bench for reg_sweeper: default, wrap-high (START=30) and wrap-low (START=1)
// instances share all inputs; each phase checks the instance(s) it targets.
module tb_reg_sweeper;

  logic       clock;
  logic       reset;
  logic       go;
  logic [1:0] mode;
  logic       hold;

  logic [4:0] regnum_a, regnum_b, regnum_c;
  logic       active_a, active_b, active_c;
  logic       done_a, done_b, done_c;

  int n_checks;
  int n_errors;

  reg_sweeper u_dut_a (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .mode   (mode),
    .hold   (hold),
    .regnum (regnum_a),
    .active (active_a),
    .done   (done_a)
  );

  reg_sweeper #(
    .REGW  (5),
    .START (30),
    .COUNT (4)
  ) u_dut_b (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .mode   (mode),
    .hold   (hold),
    .regnum (regnum_b),
    .active (active_b),
    .done   (done_b)
  );

  reg_sweeper #(
    .REGW  (5),
    .START (1),
    .COUNT (4)
  ) u_dut_c (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .mode   (mode),
    .hold   (hold),
    .regnum (regnum_c),
    .active (active_c),
    .done   (done_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input int rn, input int act, input int dn);
    check({tag, ".regnum"}, int'(regnum_a), rn);
    check({tag, ".active"}, int'(active_a), act);
    check({tag, ".done"}, int'(done_a), dn);
  endtask

  int exp_dn[4]    = '{7, 6, 5, 4};
  int exp_up[4]    = '{9, 10, 11, 12};
  int exp_wrap[4]  = '{31, 0, 1, 2};
  int exp_low[4]   = '{0, 31, 30, 29};
  int exp_ud[8]    = '{9, 10, 11, 12, 11, 10, 9, 8};
  int exp_du[8]    = '{7, 6, 5, 4, 5, 6, 7, 8};

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    go    = 1'b0;
    mode  = 2'b00;
    hold  = 1'b0;

    // Reset state.
    #12;
    check_a("reset", 0, 0, 0);
    reset = 1'b1;
    tick();
    check_a("idle", 0, 0, 0);

    // Mode 00: go high two cycles.
    go = 1'b1;
    tick();
    check_a("dn.start0", 8, 1, 0);
    tick();
    check_a("dn.start1", 8, 1, 0);
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a($sformatf("dn.k%0d", i + 1), exp_dn[i], 1, 0);
    end
    tick();
    check_a("dn.done", 0, 0, 1);
    tick();
    tick();
    check_a("dn.done_hold", 0, 0, 1);

    // Mode 01, plus wrap-around in the START=30 instance.
    mode = 2'b01;
    go   = 1'b1;
    tick();
    check_a("up.start", 8, 1, 0);
    check("wrap.start", int'(regnum_b), 30);
    go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a($sformatf("up.k%0d", i + 1), exp_up[i], 1, 0);
      check($sformatf("wrap.k%0d", i + 1), int'(regnum_b), exp_wrap[i]);
    end
    tick();
    check_a("up.done", 0, 0, 1);
    check("wrap.done", int'(done_b), 1);

    // go from DONE goes straight to START; then mode 10 with mid-sweep mode toggling.
    go = 1'b1;
    tick();
    check_a("ud.start", 8, 1, 0);
    mode = 2'b10;
    go   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_a($sformatf("ud.k%0d", i + 1), exp_ud[i], 1, 0);
      mode = (i % 2 == 0) ? 2'b00 : 2'b11;
    end
    tick();
    check_a("ud.done", 0, 0, 1);

    // Mode 11.
    go = 1'b1;
    tick();
    check_a("du.start", 8, 1, 0);
    mode = 2'b11;
    go   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_a($sformatf("du.k%0d", i + 1), exp_du[i], 1, 0);
    end
    tick();
    check_a("du.done", 0, 0, 1);

    // Mode 00 in the START=1 instance: wrap below zero.
    go = 1'b1;
    tick();
    check("low.start", int'(regnum_c), 1);
    mode = 2'b00;
    go   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("low.k%0d", i + 1), int'(regnum_c), exp_low[i]);
    end
    tick();
    check("low.done", int'(done_c), 1);

    // Hold stalls, go ignored during SWEEP, hold on the last step delays done.
    mode = 2'b01;
    go   = 1'b1;
    tick();
    go = 1'b0;
    tick();
    check_a("hold.k1", 9, 1, 0);
    tick();
    check_a("hold.k2", 10, 1, 0);
    hold = 1'b1;
    go   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("hold.stall%0d", i), 10, 1, 0);
    end
    hold = 1'b0;
    tick();
    check_a("hold.k3", 11, 1, 0);
    go = 1'b0;
    tick();
    check_a("hold.k4", 12, 1, 0);
    hold = 1'b1;
    tick();
    tick();
    check_a("hold.last", 12, 1, 0);
    hold = 1'b0;
    tick();
    check_a("hold.done", 0, 0, 1);

    // Asynchronous reset mid-sweep.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    check_a("rst.pre", 11, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_a("rst.async", 0, 0, 0);
    #2;
    reset = 1'b1;
    tick();
    tick();
    check_a("rst.idle", 0, 0, 0);
    go = 1'b1;
    tick();
    check_a("rst.start", 8, 1, 0);
    go = 1'b0;
    tick();
    check_a("rst.k1", 9, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_sweeper.md
# reg_sweeper

Parametrised register-number sweep sequencer for the register-file test datapath. On a `go` pulse it presents a configurable base register number, then steps through a configurable number of register numbers: down, up, or out-and-back. It raises `done` until the next `go`. Stepping can be stalled cycle by cycle with `hold`, so the sequencer can sit in front of a register-file write port that is not always ready.

## Interface
Parameters:
- `REGW`, 5, width of register numbers; all arithmetic is modulo 2^REGW.
- `START`, 8, base register number presented in START state (0 .. 2^REGW-1).
- `COUNT`, 4, steps per leg (1 .. 2^REGW-1).

Ports:
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `go`  in  1  start request, level-sampled.
- `mode`  in  2  00 down, 01 up, 10 up-then-down, 11 down-then-up.
- `hold`  in  1  stall stepping in SWEEP.
- `regnum`  out  REGW  current register number.
- `active`  out  1  high in START and SWEEP.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, START, SWEEP, DONE. All outputs are registered-state decodes.
- IDLE: `regnum`=0, `active`=0, `done`=0.
  - `go`=1 → START.
  - `go`=0 → stay in IDLE.
- START: `regnum`=START, `active`=1.
  - `go`=1 → stay in START.
  - `go`=0 → SWEEP. On this same edge, latch `mode` into `mode_q` and clear step index k to 1.
- SWEEP: `active`=1. `regnum` = START + off(k) mod 2^REGW, where off(k) is set by `mode_q`:
  - 00: −k, for k = 1..COUNT.
  - 01: +k, for k = 1..COUNT.
  - 10: +k for k ≤ COUNT, then +(2·COUNT − k) for k = COUNT+1 .. 2·COUNT. The final step returns to START.
  - 11: mirror of 10 with negative offsets.
  - Last k: COUNT for modes 00/01; 2·COUNT for modes 10/11.
- SWEEP transitions:
  - `hold`=1: k and `regnum` frozen, no advance.
  - `hold`=0 and k < last: k increments.
  - `hold`=0 and k = last: → DONE.
- DONE: `done`=1, `active`=0, `regnum`=0.
  - `go`=1 → START.
  - `go`=0 → stay in DONE.
- Ignored inputs:
  - `go` is ignored in SWEEP. A sweep always completes unless reset intervenes.
  - `mode` changes after the latch edge are ignored.
- Wrap-around: offsets are computed modulo 2^REGW with no saturation. Example: START=30, REGW=5, up → 31, 0, 1, …
- k counter width: clog2(2·COUNT+1) bits.

## Timing
- Reset (`reset`=0, asynchronous): immediately forces IDLE, `regnum`=0, `active`=0, `done`=0, k=0, `mode_q`=00. This applies in any state, including mid-sweep. Release is sampled at the next rising edge.
- `go` sampled high in IDLE/DONE → `regnum`=START from the next cycle.
- START lasts as long as `go` stays high, minimum 1 cycle.
- The first SWEEP value appears the cycle after `go` is sampled low.
- Each sweep value is held one cycle per non-held edge. With `hold`=0 throughout, SWEEP occupies exactly COUNT cycles (modes 00/01) or 2·COUNT cycles (modes 10/11).
- `done` rises the cycle after the last sweep value is shown.
- Simultaneous `hold`=1 on the last step: stay on the last value; no transition to DONE until `hold`=0.
- A `go` that is high in DONE and still high afterwards re-enters START. No extra idle cycle is inserted.

## Test plan
- Defaults, `mode`=00, go high 2 cycles then low → `regnum` 8, 8, 7, 6, 5, 4, then 0 with `done`=1. `done` stays 1 while `go`=0.
- Defaults, `mode`=01 → 8, 9, 10, 11, 12, then `done`. Then `go`=1 from DONE → `regnum`=8 next cycle, `done`=0.
- Defaults, `mode`=10 → 8, 9, 10, 11, 12, 11, 10, 9, 8, then `done`. `mode`=11 → 8, 7, 6, 5, 4, 5, 6, 7, 8. Toggling `mode` mid-sweep has no effect.
- REGW=5, START=30, COUNT=4: up → 30, 31, 0, 1, 2. Down with START=1 → 1, 0, 31, 30, 29.
- Defaults up; `hold`=1 for 3 cycles while `regnum`=10 → 10 shown 4 cycles, then 11, 12, `done`. `hold`=1 on 12 delays `done` accordingly. `go`=1 during SWEEP is ignored.
- Assert `reset`=0 between clock edges while `regnum`=11 → outputs go to 0 immediately (no edge needed). After release with `go`=0 → stay in IDLE. With `go`=1 → START=8.
